nibble_serial_add_ctrl: RTL and testbench

Sequencer that performs WIDTH-bit additions by time-multiplexing a single 4-bit ripple adder slice, one nibble per clock, least-significant nibble first.
- Registers the inter-nibble carry and accumulates the result in a shift register.
- Presents a start/busy/done handshake to the requesting logic.
- Sits between control logic and the shared 4-bit adder datapath. This trades latency for area when wide adds are infrequent.

---
 rtl/nibble_serial_add_ctrl_pkg.sv | 12 +
 rtl/nibble_serial_add_ctrl_fa4.sv | 23 ++
 rtl/nibble_serial_add_ctrl.sv | 110 +++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer.
// Contents: controller state encoding and the slice width constant.
package nibble_serial_add_ctrl_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_fa4.sv
// Combinational 4-bit adder slice, shared by the nibble-serial sequencer.
// Ports:
//   i_a, i_b  : 4-bit addends
//   i_c_in    : carry in
//   o_sum     : 4-bit sum
//   o_c_out   : carry out of bit 3
module nibble_serial_add_ctrl_fa4
  import nibble_serial_add_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_c_in,
  output logic [NIBBLE_W-1:0] o_sum,
  output logic                o_c_out
);

  logic [NIBBLE_W:0] w_full;

  assign w_full  = (NIBBLE_W+1)'(i_a) + (NIBBLE_W+1)'(i_b) + (NIBBLE_W+1)'(i_c_in);
  assign o_sum   = w_full[NIBBLE_W-1:0];
  assign o_c_out = w_full[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit adder built from one 4-bit slice used once per clock, LS nibble first.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : request, accepted only while idle
//   a, b, c_in   : operands and carry-in, captured with an accepted start
//   busy         : operation in progress
//   done         : one-cycle pulse when sum/c_out/ovf are updated
//   sum, c_out   : result and carry out of the last completed operation
//   ovf          : two's-complement overflow of the last completed operation
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
      $error("nibble_serial_add_ctrl: WIDTH must be a non-zero multiple of 4");
    end
  endgenerate

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic               r_carry;

  logic [NIBBLE_W-1:0] w_slice_sum;
  logic                w_slice_co;
  logic                w_carry_msb;
  logic [WIDTH-1:0]    w_res_next;

  nibble_serial_add_ctrl_fa4 u_slice (
    .i_a     (r_a[NIBBLE_W-1:0]),
    .i_b     (r_b[NIBBLE_W-1:0]),
    .i_c_in  (r_carry),
    .o_sum   (w_slice_sum),
    .o_c_out (w_slice_co)
  );

  // New slice result enters at the MSB end; after NIBBLES shifts the LS nibble sits at bit 0.
  assign w_res_next  = (r_res >> NIBBLE_W) | (WIDTH'(w_slice_sum) << (WIDTH - NIBBLE_W));
  // Carry into the result MSB, recovered from the top bit of the final slice.
  assign w_carry_msb = r_a[NIBBLE_W-1] ^ r_b[NIBBLE_W-1] ^ w_slice_sum[NIBBLE_W-1];

  // Sequencer: operand capture, per-nibble shift/accumulate, result publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= c_in;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> NIBBLE_W;
          r_b     <= r_b >> NIBBLE_W;
          r_res   <= w_res_next;
          r_carry <= w_slice_co;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            sum     <= w_res_next;
            c_out   <= w_slice_co;
            ovf     <= w_carry_msb ^ w_slice_co;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (WIDTH=16): directed cases plus
// randomized operations compared against an arithmetic reference model.
module tb_nibble_serial_add_ctrl;

  localparam int unsigned W   = 16;
  localparam int unsigned NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model view of the last completed operation.
  logic [W-1:0] exp_sum = '0;
  logic         exp_co  = 1'b0;
  logic         exp_ovf = 1'b0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer addition; signed overflow when equal-sign operands give a differently signed result.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W:0] full;
    logic       v;
    full = (W+1)'(x) + (W+1)'(y) + (W+1)'(ci);
    v    = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return {v, full};
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_sum"},  32'(sum),  32'(exp_sum));
    chk({tag, "_cout"}, 32'(c_out), 32'(exp_co));
    chk({tag, "_ovf"},  32'(ovf),  32'(exp_ovf));
  endtask

  // Starts one operation from the current (idle) cycle and returns in its done cycle.
  // inj >= 0 asserts a stray start with other operands in busy cycle inj+1.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input int inj);
    logic [W+1:0] r;
    r     = ref_add(x, y, ci);
    a     = x;
    b     = y;
    c_in  = ci;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    c_in  = 1'($urandom);
    for (int k = 0; k < int'(NIB); k++) begin
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_done", 32'(done), 32'd0);
      chk("run_sum_hold", 32'(sum), 32'(exp_sum));
      if (k == inj) begin
        start = 1'b1;
        a     = 16'hAAAA;
        b     = W'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start   = 1'b0;
    exp_sum = r[W-1:0];
    exp_co  = r[W];
    exp_ovf = r[W+1];
    chk("end_done", 32'(done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_sum",  32'(sum),  32'(exp_sum));
    chk("end_cout", 32'(c_out), 32'(exp_co));
    chk("end_ovf",  32'(ovf),  32'(exp_ovf));
  endtask

  task automatic directed(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                          input int inj, input logic [W-1:0] es, input logic eco, input logic eov);
    run_op(x, y, ci, inj);
    chk({tag, "_sum"},  32'(sum),   32'(es));
    chk({tag, "_cout"}, 32'(c_out), 32'(eco));
    chk({tag, "_ovf"},  32'(ovf),   32'(eov));
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 16'hFFFF;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      3:       return 16'h0000;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    c_in  = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();
    chk_idle("post_reset");

    directed("basic", 16'h1234, 16'h4321, 1'b0, -1, 16'h5555, 1'b0, 1'b0);
    tick();
    chk_idle("gap1");
    directed("carry_chain", 16'hFFFF, 16'h0000, 1'b1, -1, 16'h0000, 1'b1, 1'b0);
    tick();
    directed("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, -1, 16'h8000, 1'b0, 1'b1);
    tick();
    directed("neg_ovf", 16'h8000, 16'h8000, 1'b0, -1, 16'h0000, 1'b1, 1'b1);
    tick();

    // Stray start in busy cycle 2, then back-to-back start in the done cycle.
    directed("ignore_start", 16'h0001, 16'h0001, 1'b0, 1, 16'h0002, 1'b0, 1'b0);
    directed("back_to_back", 16'h00FF, 16'h0001, 1'b0, -1, 16'h0100, 1'b0, 1'b0);
    tick();
    chk_idle("after_b2b");

    // Abort in RUN cycle 2.
    a     = 16'h1111;
    b     = 16'h1111;
    c_in  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    exp_sum = '0;
    exp_co  = 1'b0;
    exp_ovf = 1'b0;
    chk_idle("abort");
    for (int k = 0; k < int'(NIB) + 1; k++) begin
      tick();
      chk_idle("abort_quiet");
    end

    // Reset and start together: start must be dropped.
    rst   = 1'b1;
    start = 1'b1;
    a     = 16'h0F0F;
    b     = 16'h0101;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk_idle("rst_start");
    tick();
    chk_idle("rst_start_next");

    directed("wrap", 16'h0F0F, 16'hF0F1, 1'b0, -1, 16'h0000, 1'b1, 1'b0);

    // Randomized operations with idle gaps and stray starts.
    for (int n = 0; n < 150; n++) begin
      int gap;
      int inj;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        tick();
        chk_idle("rnd_idle");
      end
      inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NIB - 1)) : -1;
      run_op(pick_operand(), pick_operand(), 1'($urandom), inj);
    end
    tick();
    chk_idle("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
